regfile_sb: RTL and testbench

//  Parametrised register file for the processor core: one write port, two

---
 rtl/regfile_sb.sv | 63 ++++++
 tb/tb_regfile_sb.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with hardwired-zero r0, debug tap and busy scoreboard; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TAP_REG    = 29
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  output logic [DATA_WIDTH-1:0] data_tap,
  input  logic                  ctrl_markBusy,
  input  logic [ADDR_WIDTH-1:0] ctrl_busyReg,
  output logic                  busyA,
  output logic                  busyB,
  output logic                  busy_any
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] TAP = ADDR_WIDTH'(TAP_REG);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy, busy_next;
  logic wr_ok, mark_ok;
  assign wr_ok   = ctrl_writeEnable && ctrl_writeReg != '0;
  assign mark_ok = ctrl_markBusy && ctrl_busyReg != '0;
  // clear by writeback first, then set by issue, so a same-edge set wins
  always_comb begin
    busy_next = busy;
    if (ctrl_writeEnable) busy_next[ctrl_writeReg] = 1'b0;
    if (mark_ok) busy_next[ctrl_busyReg] = 1'b1;
  end
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) regs[ctrl_writeReg] <= data_writeReg;
      busy <= busy_next;
    end
  end
  assign busy_any = |busy;
`ifdef REGFILE_BYPASS_EN
  logic hit_a, hit_b, hit_t;
  assign hit_a = wr_ok && ctrl_writeReg == ctrl_readRegA;
  assign hit_b = wr_ok && ctrl_writeReg == ctrl_readRegB;
  assign hit_t = wr_ok && ctrl_writeReg == TAP;
  assign data_readRegA = hit_a ? data_writeReg : regs[ctrl_readRegA];
  assign data_readRegB = hit_b ? data_writeReg : regs[ctrl_readRegB];
  assign data_tap      = hit_t ? data_writeReg : regs[TAP];
  assign busyA = hit_a ? (ctrl_markBusy && ctrl_busyReg == ctrl_readRegA) : busy[ctrl_readRegA];
  assign busyB = hit_b ? (ctrl_markBusy && ctrl_busyReg == ctrl_readRegB) : busy[ctrl_readRegB];
`else
  assign data_readRegA = regs[ctrl_readRegA];
  assign data_readRegB = regs[ctrl_readRegB];
  assign data_tap      = regs[TAP];
  assign busyA = busy[ctrl_readRegA];
  assign busyB = busy[ctrl_readRegB];
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic checked every cycle against an array model
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 0, ctrl_reset = 1;
  logic ctrl_writeEnable = 0, ctrl_markBusy = 0;
  logic [4:0] ctrl_writeReg = 0, ctrl_readRegA = 0, ctrl_readRegB = 0, ctrl_busyReg = 0;
  logic [31:0] data_writeReg = 0;
  logic [31:0] data_readRegA, data_readRegB, data_tap;
  logic busyA, busyB, busy_any;
  int errors = 0, checks = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  regfile_sb dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB), .data_tap(data_tap),
    .ctrl_markBusy(ctrl_markBusy), .ctrl_busyReg(ctrl_busyReg),
    .busyA(busyA), .busyB(busyB), .busy_any(busy_any)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // model: architectural state updated by the spec's edge rules
  always @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      m_busy = 0;
    end else begin
      if (ctrl_writeEnable && ctrl_writeReg != 0) m_regs[ctrl_writeReg] = data_writeReg;
      if (ctrl_writeEnable) m_busy[ctrl_writeReg] = 1'b0;
      if (ctrl_markBusy && ctrl_busyReg != 0) m_busy[ctrl_busyReg] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] r);
    if (BYP && !ctrl_reset && ctrl_writeEnable && ctrl_writeReg != 0 && ctrl_writeReg == r) return data_writeReg;
    return m_regs[r];
  endfunction

  function automatic logic exp_busy(input logic [4:0] r);
    if (BYP && !ctrl_reset && ctrl_writeEnable && ctrl_writeReg != 0 && ctrl_writeReg == r)
      return ctrl_markBusy && ctrl_busyReg == r;
    return m_busy[r];
  endfunction

  always @(negedge clock) begin
    chk("readA", data_readRegA, exp_data(ctrl_readRegA));
    chk("readB", data_readRegB, exp_data(ctrl_readRegB));
    chk("tap", data_tap, exp_data(5'd29));
    chk("busyA", {31'b0, busyA}, {31'b0, exp_busy(ctrl_readRegA)});
    chk("busyB", {31'b0, busyB}, {31'b0, exp_busy(ctrl_readRegB)});
    chk("busy_any", {31'b0, busy_any}, {31'b0, m_busy != 0});
  end

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic mk, input logic [4:0] br);
    ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd;
    ctrl_readRegA = ra; ctrl_readRegB = rb; ctrl_markBusy = mk; ctrl_busyReg = br;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    tick; tick;
    ctrl_reset = 0;
    // async reset mid-cycle
    drive(1, 5, 32'hDEADBEEF, 5, 0, 0, 0); tick;
    drive(0, 0, 0, 5, 0, 1, 6); tick;
    drive(0, 0, 0, 5, 6, 0, 0); #1;
    chk("t1_pre_readA", data_readRegA, 32'hDEADBEEF);
    chk("t1_pre_busyB", {31'b0, busyB}, 32'd1);
    #2 ctrl_reset = 1; #1;
    chk("t1_rst_readA", data_readRegA, 32'h0);
    chk("t1_rst_busy_any", {31'b0, busy_any}, 32'd0);
    tick; ctrl_reset = 0;
    // r0 hardwired, r31 write
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0); tick;
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("t2_r0_A", data_readRegA, 32'h0);
    chk("t2_r0_B", data_readRegB, 32'h0);
    drive(1, 31, 32'h12345678, 0, 0, 0, 0); tick;
    drive(0, 0, 0, 31, 0, 0, 0); #1;
    chk("t2_r31", data_readRegA, 32'h12345678);
    // busy set then cleared by writeback
    drive(0, 0, 0, 7, 0, 1, 7); tick;
    drive(0, 0, 0, 7, 0, 0, 0); #1;
    chk("t3_busyA", {31'b0, busyA}, 32'd1);
    chk("t3_busy_any", {31'b0, busy_any}, 32'd1);
    drive(1, 7, 32'h55, 7, 0, 0, 0); tick;
    drive(0, 0, 0, 7, 0, 0, 0); #1;
    chk("t3_clr_busyA", {31'b0, busyA}, 32'd0);
    chk("t3_data", data_readRegA, 32'h55);
    chk("t3_clr_any", {31'b0, busy_any}, 32'd0);
    // same-edge set and write: set wins, data updates
    drive(1, 9, 32'hA5, 0, 0, 1, 9); tick;
    drive(0, 0, 0, 9, 0, 0, 0); #1;
    chk("t4_busyA", {31'b0, busyA}, 32'd1);
    chk("t4_data", data_readRegA, 32'hA5);
    drive(1, 9, 32'h3C, 9, 0, 0, 0); tick;
    drive(0, 0, 0, 9, 0, 0, 0); #1;
    chk("t4_clr", {31'b0, busyA}, 32'd0);
    chk("t4_data2", data_readRegA, 32'h3C);
    // write and read same cycle
    drive(1, 12, 32'h77, 12, 0, 0, 0); #1;
    chk("t5_same", data_readRegA, BYP ? 32'h77 : 32'h0);
    tick;
    drive(0, 0, 0, 12, 0, 0, 0); #1;
    chk("t5_next", data_readRegA, 32'h77);
    // tap and r0 never busy
    drive(1, 29, 32'h0000FFF0, 0, 0, 0, 0); tick;
    drive(0, 0, 0, 0, 0, 1, 0); #1;
    chk("t6_tap", data_tap, 32'h0000FFF0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("t6_r0_busy", {31'b0, busy_any}, 32'd0);
    // randomized traffic; narrow index range some of the time to force collisions
    for (int n = 0; n < 3000; n++) begin
      logic narrow;
      narrow = ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 2) != 0,
            narrow ? 5'($urandom_range(0, 3)) : 5'($urandom),
            $urandom,
            narrow ? 5'($urandom_range(0, 3)) : 5'($urandom),
            narrow ? 5'($urandom_range(0, 3)) : 5'($urandom),
            $urandom_range(0, 2) == 0,
            narrow ? 5'($urandom_range(0, 3)) : 5'($urandom));
      if (n % 8 == 3) ctrl_writeReg = 5'd29;
      if ($urandom_range(0, 299) == 0) begin
        #2 ctrl_reset = 1;
        tick;
        ctrl_reset = 0;
      end else tick;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
